// File: rtl/gpi_debounce_ctrl.sv
// rtl/gpi_debounce_ctrl.sv - shared-prescaler debouncer for push-buttons and slide-switches
// Per-channel saturating counters accept a new level after StableTicks consecutive mismatching ticks.
module gpi_debounce_ctrl #(
  parameter int Width       = 20,
  parameter int TickDiv     = 50000,
  parameter int StableTicks = 10
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] raw_i,
  output logic [Width-1:0] stable_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic [Width-1:0] pending_o,
  input  logic [Width-1:0] pending_clr_i,
  output logic             tick_o
);

  localparam int PW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int CW = $clog2(StableTicks + 1);
  localparam logic [PW-1:0] PreLast = PW'(TickDiv - 1);
  localparam logic [CW-1:0] CntLast = CW'(StableTicks - 1);

  typedef enum logic {
    ST_IDLE,
    ST_COUNT
  } ch_state_t;

  logic [Width-1:0] sync_q1;
  logic [Width-1:0] sync_q2;
  logic [PW-1:0]    pre_q;
  logic [PW-1:0]    pre_d;
  logic             tick;
  logic [CW-1:0]    cnt_q [Width];
  logic [CW-1:0]    cnt_d [Width];
  ch_state_t        state [Width];
  logic [Width-1:0] stable_q;
  logic [Width-1:0] stable_d;
  logic [Width-1:0] rise_q;
  logic [Width-1:0] fall_q;
  logic [Width-1:0] pending_q;

  // Tick is masked during reset so the strobe stays low even when TickDiv=1.
  always_comb begin
    tick  = ~rst_sys_i & (pre_q == PreLast);
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  // Channel state is implied by the synchronised level disagreeing with the accepted one.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < Width; i++) begin
      state[i] = (sync_q2[i] != stable_q[i]) ? ST_COUNT : ST_IDLE;
      cnt_d[i] = '0;
      case (state[i])
        ST_IDLE: cnt_d[i] = '0;
        ST_COUNT: begin
          if (!tick) begin
            cnt_d[i] = cnt_q[i];
          end else if (cnt_q[i] == CntLast) begin
            stable_d[i] = sync_q2[i];
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: cnt_d[i] = '0;
      endcase
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      sync_q1   <= '0;
      sync_q2   <= '0;
      pre_q     <= '0;
      stable_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      pending_q <= '0;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync_q1   <= raw_i;
      sync_q2   <= sync_q1;
      pre_q     <= pre_d;
      stable_q  <= stable_d;
      rise_q    <= stable_d & ~stable_q;
      fall_q    <= ~stable_d & stable_q;
      // A rise in the same cycle as a clear keeps the flag set.
      pending_q <= (pending_q & ~pending_clr_i) | rise_q;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign stable_o  = stable_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign pending_o = pending_q;
  assign tick_o    = tick;

endmodule

// File: tb/tb_gpi_debounce_ctrl.sv
// tb/tb_gpi_debounce_ctrl.sv - directed scoreboard bench for gpi_debounce_ctrl
module tb_gpi_debounce_ctrl;
  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] raw;
  logic [W-1:0] stable;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] pending;
  logic [W-1:0] clr;
  logic         tick;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  gpi_debounce_ctrl #(
    .Width(W),
    .TickDiv(4),
    .StableTicks(3)
  ) dut (
    .clk_sys_i(clk),
    .rst_sys_i(rst),
    .raw_i(raw),
    .stable_o(stable),
    .rise_o(rise),
    .fall_o(fall),
    .pending_o(pending),
    .pending_clr_i(clr),
    .tick_o(tick)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_bit(input int b, input logic v, output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (stable[b] !== v && c < 60);
  endtask

  // Every rise/fall pulse must match the next expected {rise,fall} pair pushed by the stimulus.
  always @(negedge clk) begin : mon
    logic [2*W-1:0] e;
    if ((rise | fall) !== '0) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk("edge_pulse", {rise, fall}, e);
    end
  end

  initial begin
    int c;
    int n;
    int g;
    logic bs;

    // 1: reset state and prescaler phase
    rst = 1'b1;
    raw = '0;
    clr = '0;
    repeat (3) @(negedge clk);
    chk("rst_stable", stable, 0);
    chk("rst_rise", rise, 0);
    chk("rst_fall", fall, 0);
    chk("rst_pending", pending, 0);
    chk("rst_tick", tick, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("tick_phase", tick, (k % 4 == 3));
    end

    // 2: clean rising edge on bit 0
    raw[0] = 1'b1;
    exp_q.push_back({20'h00001, 20'h00000});
    wait_bit(0, 1'b1, c);
    chk("b0_latency_window", (c >= 11 && c <= 15), 1);
    chk("b0_rise_on", rise[0], 1);
    @(negedge clk);
    chk("b0_rise_off", rise[0], 0);
    chk("b0_pending", pending[0], 1);
    repeat (5) @(negedge clk);
    chk("b0_pending_sticky", pending[0], 1);

    // 3: bouncing bit 5 must not change, then one rise after settling
    bs = 1'b0;
    for (int r = 0; r < 10; r++) begin
      raw[5] = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (stable[5]) bs = 1'b1;
      end
      raw[5] = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (stable[5]) bs = 1'b1;
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (stable[5]) bs = 1'b1;
    end
    chk("b5_bounce_stable", bs, 0);
    raw[5] = 1'b1;
    exp_q.push_back({20'h00020, 20'h00000});
    wait_bit(5, 1'b1, c);
    chk("b5_latency_window", (c >= 11 && c <= 15), 1);
    repeat (20) @(negedge clk);
    chk("b5_settled", stable[5], 1);

    // 4: pending clear, and clear coinciding with a rise
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    chk("b0_cleared", pending[0], 0);
    chk("b5_untouched", pending[5], 1);
    raw[0] = 1'b0;
    exp_q.push_back({20'h00000, 20'h00001});
    wait_bit(0, 1'b0, c);
    chk("b0_fell", stable[0], 0);
    raw[0] = 1'b1;
    exp_q.push_back({20'h00001, 20'h00000});
    wait_bit(0, 1'b1, c);
    chk("b0_rise_again", rise[0], 1);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    chk("set_wins_over_clear", pending[0], 1);

    // 5: all inputs high through reset release
    raw = '1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst2_stable", stable, 0);
    chk("rst2_pending", pending, 0);
    chk("rst2_fall", fall, 0);
    rst = 1'b0;
    exp_q.push_back({20'hFFFFF, 20'h00000});
    wait_bit(19, 1'b1, c);
    chk("all_stable", stable, 20'hFFFFF);
    chk("all_rise", rise, 20'hFFFFF);
    @(negedge clk);
    chk("all_pending", pending, 20'hFFFFF);
    chk("all_rise_off", rise, 0);

    // 6: reset during a partial count on bit 19
    raw[19] = 1'b0;
    exp_q.push_back({20'h00000, 20'h80000});
    wait_bit(19, 1'b0, c);
    chk("b19_fell", stable, 20'h7FFFF);
    raw[19] = 1'b1;
    repeat (2) @(negedge clk);
    n = 0;
    g = 0;
    while (n < 2 && g < 40) begin
      if (tick) n++;
      if (n < 2) begin
        @(negedge clk);
        g++;
      end
    end
    chk("b19_two_ticks", n, 2);
    @(negedge clk);
    chk("b19_not_yet", stable[19], 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst3_stable", stable, 0);
    chk("rst3_fall", fall, 0);
    rst = 1'b0;
    exp_q.push_back({20'hFFFFF, 20'h00000});
    wait_bit(19, 1'b1, c);
    chk("b19_redebounce", (c >= 11 && c <= 15), 1);
    chk("rst3_all_stable", stable, 20'hFFFFF);

    repeat (10) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
